// File: rtl/edge_pulse_gen_mc.sv
// Multi-channel edge pulse generator.
// Each channel synchronises an async level, detects rise/fall/both edges
// (selected at run time) and emits a registered pulse stretched to PULSE_W cycles.
// Detection is masked for SYNC_STAGES+1 cycles after reset release so that a
// level already high during reset does not produce a spurious pulse.
// Optional build macro EDGE_CNT_EN adds per-channel 8-bit saturating event
// counters (evt_cnt) with a synchronous clear (evt_clr).
module edge_pulse_gen_mc #(
   parameter int unsigned CH          = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PULSE_W     = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH-1:0]     d,
   input  logic [2*CH-1:0]   edge_mode,
`ifdef EDGE_CNT_EN
   input  logic              evt_clr,
   output logic [8*CH-1:0]   evt_cnt,
`endif
   output logic [CH-1:0]     pulse,
   output logic [CH-1:0]     busy,
   output logic              edge_any
);

   localparam int unsigned  ArmW    = $clog2(SYNC_STAGES + 2);
   localparam logic [ArmW-1:0] ArmDone = ArmW'(SYNC_STAGES + 1);
   localparam logic [7:0]   Reload  = 8'(PULSE_W - 1);

   logic [CH-1:0]   sync_q [SYNC_STAGES];
   logic [CH-1:0]   hist_q;
   logic [CH-1:0]   sv;
   logic [CH-1:0]   rise;
   logic [CH-1:0]   fall;
   logic [CH-1:0]   det_raw;
   logic [CH-1:0]   det;
   logic [ArmW-1:0] arm_q;
   logic            armed;
   logic [7:0]      cnt_q [CH];
   logic [CH-1:0]   pulse_q;
   logic            edge_any_q;

   assign sv    = sync_q[SYNC_STAGES-1];
   assign armed = (arm_q == ArmDone);

   // Synchroniser chain plus one history flop per channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         hist_q <= '0;
      end else begin
         sync_q[0] <= d;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         hist_q <= sv;
      end
   end

   // Arm counter: counts up after reset release and holds once armed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q <= '0;
      end else if (!armed) begin
         arm_q <= arm_q + 1'b1;
      end
   end

   // Per-channel edge detect, gated by the run-time mode and the arm mask.
   always_comb begin
      rise    = sv & ~hist_q;
      fall    = ~sv & hist_q;
      det_raw = '0;
      for (int i = 0; i < CH; i++) begin
         det_raw[i] = (edge_mode[2*i] & rise[i]) | (edge_mode[2*i+1] & fall[i]);
      end
      det = armed ? det_raw : '0;
   end

   // Stretch counters: a detect (re)loads PULSE_W-1, otherwise count down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            cnt_q[i] <= '0;
         end
         pulse_q    <= '0;
         edge_any_q <= 1'b0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (det[i]) begin
               cnt_q[i]   <= Reload;
               pulse_q[i] <= 1'b1;
            end else if (cnt_q[i] != 8'd0) begin
               cnt_q[i]   <= cnt_q[i] - 8'd1;
               pulse_q[i] <= 1'b1;
            end else begin
               pulse_q[i] <= 1'b0;
            end
         end
         edge_any_q <= |det;
      end
   end

   // Busy flags follow the stretch counters directly.
   always_comb begin
      busy = '0;
      for (int i = 0; i < CH; i++) begin
         busy[i] = (cnt_q[i] != 8'd0);
      end
   end

   assign pulse    = pulse_q;
   assign edge_any = edge_any_q;

`ifdef EDGE_CNT_EN
   logic [7:0] evt_q [CH];

   // Saturating event counters; clear takes priority over a same-cycle detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            evt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (evt_clr) begin
               evt_q[i] <= '0;
            end else if (det[i] && (evt_q[i] != 8'hff)) begin
               evt_q[i] <= evt_q[i] + 8'd1;
            end
         end
      end
   end

   // Flatten counters onto the output bus, channel i at bits [8i+7:8i].
   always_comb begin
      evt_cnt = '0;
      for (int i = 0; i < CH; i++) begin
         evt_cnt[8*i +: 8] = evt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_edge_pulse_gen_mc.sv
// Directed testbench for edge_pulse_gen_mc.
// Two instances share stimulus: u1 with PULSE_W=1 and u4 with PULSE_W=4.
// Counter checks are included when EDGE_CNT_EN is defined.
module tb_edge_pulse_gen_mc;

   logic       clk;
   logic       rst_n;
   logic [3:0] d;
   logic [7:0] edge_mode;
   logic [3:0] pulse1, busy1, pulse4, busy4;
   logic       any1, any4;
`ifdef EDGE_CNT_EN
   logic        evt_clr;
   logic [31:0] evt_cnt1, evt_cnt4;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int cnt_p1, cnt_p2, first1, first2, last2;

   edge_pulse_gen_mc #(.CH(4), .SYNC_STAGES(2), .PULSE_W(1)) u1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .d         (d),
      .edge_mode (edge_mode),
`ifdef EDGE_CNT_EN
      .evt_clr   (evt_clr),
      .evt_cnt   (evt_cnt1),
`endif
      .pulse     (pulse1),
      .busy      (busy1),
      .edge_any  (any1)
   );

   edge_pulse_gen_mc #(.CH(4), .SYNC_STAGES(2), .PULSE_W(4)) u4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .d         (d),
      .edge_mode (edge_mode),
`ifdef EDGE_CNT_EN
      .evt_clr   (evt_clr),
      .evt_cnt   (evt_cnt4),
`endif
      .pulse     (pulse4),
      .busy      (busy4),
      .edge_any  (any4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset with all inputs high: arming must suppress any pulse.
      rst_n     = 1'b0;
      d         = 4'b1111;
      edge_mode = 8'b01010101;
`ifdef EDGE_CNT_EN
      evt_clr   = 1'b0;
`endif
      tick(3);
      chk("rst_pulse1", 32'(pulse1), 32'h0);
      chk("rst_busy4", 32'(busy4), 32'h0);
      chk("rst_any1", 32'(any1), 32'h0);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick(1);
         chk("hold_pulse1", 32'(pulse1), 32'h0);
         chk("hold_pulse4", 32'(pulse4), 32'h0);
         chk("hold_any1", 32'(any1), 32'h0);
      end

      // Rise latency on channel 0.
      edge_mode = 8'b00000001;
      d         = 4'b0000;
      tick(5);
      d = 4'b0001;
      tick(1);
      chk("lat_e0", 32'(pulse1), 32'h0);
      tick(1);
      chk("lat_e1", 32'(pulse1), 32'h0);
      tick(1);
      chk("lat_e2_pulse1", 32'(pulse1), 32'h1);
      chk("lat_e2_any1", 32'(any1), 32'h1);
      chk("lat_e2_busy1", 32'(busy1), 32'h0);
      chk("lat_e2_pulse4", 32'(pulse4), 32'h1);
      chk("lat_e2_busy4", 32'(busy4), 32'h1);
      tick(1);
      chk("lat_e3_pulse1", 32'(pulse1), 32'h0);
      chk("lat_e3_any1", 32'(any1), 32'h0);
      chk("lat_e3_pulse4", 32'(pulse4), 32'h1);
      tick(2);
      chk("w4_last_pulse", 32'(pulse4), 32'h1);
      chk("w4_last_busy", 32'(busy4), 32'h0);
      tick(1);
      chk("w4_end_pulse", 32'(pulse4), 32'h0);
      d = 4'b0000;
      tick(8);
      chk("rise_only_fall", 32'(pulse1), 32'h0);

      // Fall on channel 1, both edges on channel 2, 5-cycle high pulse.
      edge_mode = 8'b00111000;
      cnt_p1 = 0; cnt_p2 = 0; first1 = -1; first2 = -1; last2 = -1;
      d = 4'b0110;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         if (pulse1[1]) begin
            cnt_p1++;
            if (first1 < 0) first1 = c;
         end
         if (pulse1[2]) begin
            cnt_p2++;
            if (first2 < 0) first2 = c;
            last2 = c;
         end
         if (pulse1[0] || pulse1[3]) cnt_p1 += 100;
         if (c == 4) d = 4'b0000;
      end
      chk("fall_count", 32'(cnt_p1), 32'd1);
      chk("fall_cycle", 32'(first1), 32'd7);
      chk("both_count", 32'(cnt_p2), 32'd2);
      chk("both_first", 32'(first2), 32'd2);
      chk("both_last", 32'(last2), 32'd7);

      // Stretch with retrigger on channel 3 (mode both): rise, fall, rise.
      edge_mode = 8'b11000000;
      d = 4'b1000;
      tick(1);
      d = 4'b0000;
      tick(1);
      d = 4'b1000;
      tick(1);
      for (int k = 0; k < 8; k++) begin
         chk("retrig_pulse4", 32'(pulse4[3]), (k <= 5) ? 32'd1 : 32'd0);
         chk("retrig_busy4", 32'(busy4[3]), (k <= 4) ? 32'd1 : 32'd0);
         chk("toggle_pulse1", 32'(pulse1[3]), (k <= 2) ? 32'd1 : 32'd0);
         tick(1);
      end

      // Switching mode off mid-stretch must not truncate the pulse.
      d = 4'b0000;
      tick(3);
      chk("modeoff_c0", 32'(pulse4[3]), 32'd1);
      edge_mode = 8'b00000000;
      tick(3);
      chk("modeoff_c3_pulse", 32'(pulse4[3]), 32'd1);
      chk("modeoff_c3_busy", 32'(busy4[3]), 32'd0);
      tick(1);
      chk("modeoff_c4_pulse", 32'(pulse4[3]), 32'd0);

      // Asynchronous reset in the middle of a stretch.
      edge_mode = 8'b00000001;
      d = 4'b0001;
      tick(3);
      chk("pre_rst_pulse4", 32'(pulse4), 32'h1);
      tick(2);
      chk("pre_rst_busy4", 32'(busy4), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_pulse4", 32'(pulse4), 32'h0);
      chk("async_busy4", 32'(busy4), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick(1);
         chk("rearm_pulse1", 32'(pulse1), 32'h0);
         chk("rearm_pulse4", 32'(pulse4), 32'h0);
      end
      d = 4'b0000;
      tick(3);
      d = 4'b0001;
      tick(3);
      chk("post_rearm_pulse1", 32'(pulse1), 32'h1);
      chk("post_rearm_any1", 32'(any1), 32'h1);

`ifdef EDGE_CNT_EN
      // Saturating event counters on channel 3.
      edge_mode = 8'b01000000;
      d = 4'b0000;
      tick(4);
      evt_clr = 1'b1;
      tick(1);
      evt_clr = 1'b0;
      chk("evt_clr_all", evt_cnt1, 32'h0);
      for (int r = 0; r < 300; r++) begin
         d = 4'b1000;
         tick(2);
         d = 4'b0000;
         tick(2);
      end
      tick(3);
      chk("evt_sat", evt_cnt1, 32'hff000000);
      d = 4'b1000;
      tick(2);
      evt_clr = 1'b1;
      tick(1);
      evt_clr = 1'b0;
      chk("evt_clr_wins", evt_cnt1, 32'h0);
      d = 4'b0000;
      tick(3);
      d = 4'b1000;
      tick(4);
      chk("evt_after_clr", evt_cnt1, 32'h01000000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
